// File: rtl/hc02_tester_pkg.sv
// hc02_tester_pkg: FSM states, vector ROM and shared constants for the 74HC02 exerciser.
package hc02_tester_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, FINISH} state_t;

    localparam int NUM_VEC = 6;
    localparam logic [2:0] NO_FAIL = 3'd7;

    // Vectors 4 and 5 alternate adjacent gates to expose output shorts.
    localparam logic [0:5][3:0] VEC_A = {4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0101, 4'b1010};
    localparam logic [0:5][3:0] VEC_B = {4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    localparam logic [0:5][3:0] VEC_Y = {4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0101};

endpackage

// File: rtl/hc02_tester_sync_nff.sv
// sync_nff: multi-flop synchronizer bringing the asynchronous device outputs into the clk domain.
module sync_nff #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W*STAGES-1:0] r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r <= '0;
        else     r <= {r[W*(STAGES-1)-1:0], d};
    end

    assign q = r[W*STAGES-1 -: W];

endmodule

// File: rtl/hc02_tester.sv
// hc02_tester: drives NOR test vectors into a 74HC02, samples its outputs after settling
// and reports per-gate failures and the first failing vector.
module hc02_tester
    import hc02_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    input  logic [3:0] y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] fail_vec
);

    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic [7:0] cnt;
    logic [3:0] y_sync, err;

    sync_nff #(.W(4), .STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(y_in), .q(y_sync));

    assign err = y_sync ^ VEC_Y[idx];

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE:    if (start && !done) begin
                         state_n = DRIVE;
                         idx_n   = 3'd0;
                     end
            DRIVE:   state_n = SETTLE;
            SETTLE:  state_n = (cnt == 8'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
            SAMPLE:  if (idx == 3'(NUM_VEC - 1)) state_n = FINISH;
                     else begin
                         state_n = DRIVE;
                         idx_n   = idx + 3'd1;
                     end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pins load on entry to DRIVE so the DRIVE cycle already counts toward settling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= 8'd0;
            a_out     <= 4'd0;
            b_out     <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            fail_vec  <= NO_FAIL;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= (state == SETTLE) ? cnt + 8'd1 : 8'd0;
            busy  <= state_n != IDLE;
            done  <= state == FINISH;
            a_out <= (state_n == DRIVE) ? VEC_A[idx_n] : (state_n == SETTLE || state_n == SAMPLE) ? a_out : 4'd0;
            b_out <= (state_n == DRIVE) ? VEC_B[idx_n] : (state_n == SETTLE || state_n == SAMPLE) ? b_out : 4'd0;
            if (state == IDLE && state_n == DRIVE) begin
                pass      <= 1'b0;
                fail_mask <= 4'd0;
                fail_vec  <= NO_FAIL;
            end
            if (state == SAMPLE) begin
                fail_mask <= fail_mask | err;
                if (err != 4'd0 && fail_vec == NO_FAIL) fail_vec <= idx;
            end
            if (state == FINISH) pass <= fail_mask == 4'd0;
        end
    end

endmodule

// File: tb/tb_hc02_tester.sv
// tb_hc02_tester: scoreboard bench driving two testers (settle 4 and settle 1) into
// behavioural 74HC02 models with optional faults and output delay.
module tb_hc02_tester;

    localparam int L0 = 37;
    localparam int L1 = 19;

    typedef struct {
        logic       p;
        logic [3:0] m;
        logic [2:0] v;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [3:0] a0, b0, y0, mask0, a1, b1, y1, mask1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [2:0] fvec0, fvec1;

    int   total = 0, bad = 0, cyc = 0;
    int   flt0 = 0, dly0 = 0, dly1 = 0;
    exp_t q0[$], q1[$];
    exp_t e0, e1;
    logic [3:0] h0 [8] = '{default: 4'hF};
    logic [3:0] h1 [8] = '{default: 4'hF};

    hc02_tester #(.SETTLE_CYCLES(4), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0), .fail_vec(fvec0)
    );

    hc02_tester #(.SETTLE_CYCLES(1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1), .fail_vec(fvec1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Device model: gate n drives y[n-1]; f=1 gate 3 stuck-at-0, f=2 Y2 tied to Y1.
    function automatic logic [3:0] flt(input logic [3:0] y, input int f);
        return (f == 1) ? (y & 4'b1011) : (f == 2) ? {y[3:2], y[0], y[0]} : y;
    endfunction

    always @(posedge clk) begin
        h0[0] <= ~(a0 | b0);
        h1[0] <= ~(a1 | b1);
        for (int i = 1; i < 8; i++) begin
            h0[i] <= h0[i-1];
            h1[i] <= h1[i-1];
        end
    end

    always_comb begin
        y0 = flt((dly0 == 0) ? ~(a0 | b0) : h0[dly0-1], flt0);
        y1 = flt((dly1 == 0) ? ~(a1 | b1) : h1[dly1-1], 0);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) chk("done0_unexpected", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk("pass0", 32'(pass0), 32'(e0.p));
                chk("mask0", 32'(mask0), 32'(e0.m));
                chk("fvec0", 32'(fvec0), 32'(e0.v));
                chk("done_cycle0", cyc, e0.cyc);
                chk("busy_at_done0", 32'(busy0), 0);
            end
        end
        if (done1) begin
            if (q1.size() == 0) chk("done1_unexpected", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("pass1", 32'(pass1), 32'(e1.p));
                chk("mask1", 32'(mask1), 32'(e1.m));
                chk("fvec1", 32'(fvec1), 32'(e1.v));
                chk("done_cycle1", cyc, e1.cyc);
            end
        end
    end

    task automatic go(input int u, input logic p, input logic [3:0] m, input logic [2:0] v);
        @(negedge clk);
        if (u == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        if (u == 0) q0.push_back('{p, m, v, cyc + L0});
        else        q1.push_back('{p, m, v, cyc + L1});
    endtask

    task automatic wait_done(input int u);
        int i = 0;
        while ((u == 0 ? q0.size() : q1.size()) != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (i >= 200) begin
            chk("done_timeout", u, 99);
            q0.delete();
            q1.delete();
        end
        repeat (10) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", 32'(a0), 0);
        chk("rst_b", 32'(b0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_pass", 32'(pass0), 0);
        chk("rst_mask", 32'(mask0), 0);
        chk("rst_fvec", 32'(fvec0), 7);
        chk("rst_fvec1", 32'(fvec1), 7);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // ideal device, then a start in the same cycle as done must be ignored
        go(0, 1'b1, 4'b0000, 3'd7);
        #1 chk("busy_after_start", 32'(busy0), 1);
        for (int i = 0; i < 200 && !done0; i++) @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        chk("start_on_done_ignored", 32'(busy0), 0);
        wait_done(0);

        flt0 = 1;
        go(0, 1'b0, 4'b0100, 3'd0);
        wait_done(0);
        flt0 = 2;
        go(0, 1'b0, 4'b0010, 3'd4);
        wait_done(0);
        flt0 = 0;

        // extra start pulses inside a run
        go(0, 1'b1, 4'b0000, 3'd7);
        repeat (2) @(posedge clk);
        @(negedge clk) start0 = 1'b1;
        @(posedge clk) #1 start0 = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk) start0 = 1'b1;
        @(posedge clk) #1 start0 = 1'b0;
        wait_done(0);

        // failing run leaves results, then reset during vector 2 settle clears them
        flt0 = 1;
        go(0, 1'b0, 4'b0100, 3'd0);
        wait_done(0);
        flt0 = 0;
        go(0, 1'b1, 4'b0000, 3'd7);
        repeat (13) @(posedge clk);
        #2;
        chk("vec2_a_driven", 32'(a0), 32'hF);
        rst = 1'b1;
        #1;
        q0.delete();
        chk("midrst_a", 32'(a0), 0);
        chk("midrst_b", 32'(b0), 0);
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_fvec", 32'(fvec0), 7);
        chk("midrst_done", 32'(done0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(posedge clk);
        go(0, 1'b1, 4'b0000, 3'd7);
        wait_done(0);

        // output delay at the edge of the settle window
        dly0 = 3;
        go(0, 1'b1, 4'b0000, 3'd7);
        wait_done(0);
        dly0 = 4;
        go(0, 1'b0, 4'b1111, 3'd1);
        wait_done(0);
        dly0 = 0;

        dly1 = 0;
        go(1, 1'b1, 4'b0000, 3'd7);
        wait_done(1);
        dly1 = 1;
        go(1, 1'b0, 4'b1111, 3'd1);
        wait_done(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
